// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle RV64I core.
// Holds the state codes, opcode constants, ALU-op codes and datapath
// mux-select encodings used by the control FSM, datapath and ALU decoder.
package core_pkg;

  // FSM state codes (legacy-compatible plain constants)
  typedef logic [4:0] state_t;

  localparam state_t S_IDLE     = 5'd0;
  localparam state_t S_FETCH    = 5'd1;
  localparam state_t S_DECODE   = 5'd2;
  localparam state_t S_MEMADDR  = 5'd3;
  localparam state_t S_MEMREAD  = 5'd4;
  localparam state_t S_MEMWB    = 5'd5;
  localparam state_t S_MEMWRITE = 5'd6;
  localparam state_t S_EXECR    = 5'd7;
  localparam state_t S_EXECI    = 5'd8;
  localparam state_t S_EXECRW   = 5'd9;
  localparam state_t S_EXECIW   = 5'd10;
  localparam state_t S_ALUWB    = 5'd11;
  localparam state_t S_BRANCH   = 5'd12;
  localparam state_t S_JALR     = 5'd13;
  localparam state_t S_JAL      = 5'd14;
  localparam state_t S_LUI      = 5'd15;
  localparam state_t S_AUIPC    = 5'd16;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_IW     = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU-op codes handed to the ALU decoder
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_DEC  = 2'b10;  // decode funct3/funct7 (I/R)
  localparam logic [1:0] ALU_DECW = 2'b11;  // decode, 32-bit W variants

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Multi-cycle control FSM for the RV64I core: sequences ALU, regfile and memory.
// Latency: 3..5 cycles per instruction with zero-wait memory (+1 per wait cycle).
// Backpressure: holds o_mem_req and its selects stable until i_mem_ready.
//
// Ports:
//   clk, arstn        core clock / async active-low reset
//   i_op              opcode field of the instruction register
//   i_mem_ready       memory completed the current access this cycle
//   o_mem_req/_write  memory request and store qualifier
//   o_addr_src        memory address: 0 = PC, 1 = ALU-out register
//   o_instr_write     IR load enable
//   o_pc_update       unconditional PC write
//   o_branch          conditional PC write (qualified by the datapath compare)
//   o_reg_write       register file write enable
//   o_alu_op          ALU-op code for the ALU decoder
//   o_alu_src_a/_b    ALU operand selects
//   o_result_src      result bus select
//   o_illegal_instr   one-cycle pulse on an unknown opcode in DECODE
module main_fsm
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       arstn,
  input  logic [6:0] i_op,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_write,
  output logic       o_addr_src,
  output logic       o_instr_write,
  output logic       o_pc_update,
  output logic       o_branch,
  output logic       o_reg_write,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic       o_illegal_instr
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and output decode. Outputs depend only on the state, except
  // the FETCH commit (gated by i_mem_ready) and o_illegal_instr in DECODE.
  always_comb begin
    state_nxt       = state;
    o_mem_req       = 1'b0;
    o_mem_write     = 1'b0;
    o_addr_src      = 1'b0;
    o_instr_write   = 1'b0;
    o_pc_update     = 1'b0;
    o_branch        = 1'b0;
    o_reg_write     = 1'b0;
    o_alu_op        = ALU_ADD;
    o_alu_src_a     = SRC_A_PC;
    o_alu_src_b     = SRC_B_RS2;
    o_result_src    = RES_ALUOUT;
    o_illegal_instr = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end

      S_FETCH: begin
        o_mem_req  = 1'b1;
        o_addr_src = 1'b0;
        // Commit IR load and PC+4 only in the cycle the fetch completes.
        if (i_mem_ready) begin
          o_instr_write = 1'b1;
          o_pc_update   = 1'b1;
          o_alu_src_a   = SRC_A_PC;
          o_alu_src_b   = SRC_B_FOUR;
          o_result_src  = RES_ALU;
          o_alu_op      = ALU_ADD;
          state_nxt     = S_DECODE;
        end
      end

      S_DECODE: begin
        // old PC + imm lands in ALU-out for BRANCH/JAL to use later
        o_alu_src_a = SRC_A_OLDPC;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        case (i_op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADDR;
          OP_R:              state_nxt = S_EXECR;
          OP_I:              state_nxt = S_EXECI;
          OP_RW:             state_nxt = S_EXECRW;
          OP_IW:             state_nxt = S_EXECIW;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default: begin
            o_illegal_instr = 1'b1;
            state_nxt       = S_FETCH;
          end
        endcase
      end

      S_MEMADDR: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        // bit 5 separates STORE (0100011) from LOAD (0000011)
        state_nxt   = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        o_mem_req  = 1'b1;
        o_addr_src = 1'b1;
        if (i_mem_ready) begin
          state_nxt = S_MEMWB;
        end
      end

      S_MEMWB: begin
        o_result_src = RES_RDATA;
        o_reg_write  = 1'b1;
        state_nxt    = S_FETCH;
      end

      S_MEMWRITE: begin
        o_mem_req   = 1'b1;
        o_mem_write = 1'b1;
        o_addr_src  = 1'b1;
        if (i_mem_ready) begin
          state_nxt = S_FETCH;
        end
      end

      S_EXECR: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_RS2;
        o_alu_op    = ALU_DEC;
        state_nxt   = S_ALUWB;
      end

      S_EXECI: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_DEC;
        state_nxt   = S_ALUWB;
      end

      S_EXECRW: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_RS2;
        o_alu_op    = ALU_DECW;
        state_nxt   = S_ALUWB;
      end

      S_EXECIW: begin
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_DECW;
        state_nxt   = S_ALUWB;
      end

      S_LUI: begin
        o_alu_src_a = SRC_A_ZERO;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        state_nxt   = S_ALUWB;
      end

      S_AUIPC: begin
        o_alu_src_a = SRC_A_OLDPC;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        state_nxt   = S_ALUWB;
      end

      S_ALUWB: begin
        o_result_src = RES_ALUOUT;
        o_reg_write  = 1'b1;
        state_nxt    = S_FETCH;
      end

      S_BRANCH: begin
        // compare rs1-rs2; the target was latched into ALU-out in DECODE
        o_alu_src_a  = SRC_A_RS1;
        o_alu_src_b  = SRC_B_RS2;
        o_alu_op     = ALU_SUB;
        o_result_src = RES_ALUOUT;
        o_branch     = 1'b1;
        state_nxt    = S_FETCH;
      end

      S_JALR: begin
        // rs1 + imm overwrites the DECODE target in ALU-out
        o_alu_src_a = SRC_A_RS1;
        o_alu_src_b = SRC_B_IMM;
        o_alu_op    = ALU_ADD;
        state_nxt   = S_JAL;
      end

      S_JAL: begin
        // PC <- ALU-out target while the ALU computes old PC + 4 for ALUWB
        o_alu_src_a  = SRC_A_OLDPC;
        o_alu_src_b  = SRC_B_FOUR;
        o_alu_op     = ALU_ADD;
        o_result_src = RES_ALUOUT;
        o_pc_update  = 1'b1;
        state_nxt    = S_ALUWB;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed scenarios plus random instruction stream.
// Each instruction is expanded into its expected per-cycle step list and compared.
// Memory wait cycles are random (bounded) on fetch and data accesses.
module tb_main_fsm;
  import core_pkg::*;

  logic       clk;
  logic       arstn;
  logic [6:0] i_op;
  logic       i_mem_ready;
  logic       o_mem_req;
  logic       o_mem_write;
  logic       o_addr_src;
  logic       o_instr_write;
  logic       o_pc_update;
  logic       o_branch;
  logic       o_reg_write;
  logic [1:0] o_alu_op;
  logic [1:0] o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [1:0] o_result_src;
  logic       o_illegal_instr;

  int checks;
  int failures;

  main_fsm dut (
    .clk             (clk),
    .arstn           (arstn),
    .i_op            (i_op),
    .i_mem_ready     (i_mem_ready),
    .o_mem_req       (o_mem_req),
    .o_mem_write     (o_mem_write),
    .o_addr_src      (o_addr_src),
    .o_instr_write   (o_instr_write),
    .o_pc_update     (o_pc_update),
    .o_branch        (o_branch),
    .o_reg_write     (o_reg_write),
    .o_alu_op        (o_alu_op),
    .o_alu_src_a     (o_alu_src_a),
    .o_alu_src_b     (o_alu_src_b),
    .o_result_src    (o_result_src),
    .o_illegal_instr (o_illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed in a fixed order
  logic [15:0] outv;
  assign outv = {o_mem_req, o_mem_write, o_addr_src, o_instr_write, o_pc_update,
                 o_branch, o_reg_write, o_alu_op, o_alu_src_a, o_alu_src_b,
                 o_result_src, o_illegal_instr};

  // Build an expected output vector in the same order as outv
  function automatic logic [15:0] ov(input logic mreq, input logic mwr, input logic asrc,
                                     input logic iw, input logic pcu, input logic br,
                                     input logic rw, input logic [1:0] aop,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic ill);
    return {mreq, mwr, asrc, iw, pcu, br, rw, aop, sa, sb, rs, ill};
  endfunction

  // Expected output vector for each step, straight from the operation table
  localparam logic [15:0] V_ZERO     = 16'h0000;
  localparam logic [15:0] V_FETCH_W  = ov(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] V_FETCH_R  = ov(1,0,0,1,1,0,0,2'b00,2'b00,2'b10,2'b10,0);
  localparam logic [15:0] V_DECODE   = ov(0,0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0);
  localparam logic [15:0] V_MEMADDR  = ov(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0);
  localparam logic [15:0] V_MEMREAD  = ov(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] V_MEMWB    = ov(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,0);
  localparam logic [15:0] V_MEMWRITE = ov(1,1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] V_EXECR    = ov(0,0,0,0,0,0,0,2'b10,2'b10,2'b00,2'b00,0);
  localparam logic [15:0] V_EXECI    = ov(0,0,0,0,0,0,0,2'b10,2'b10,2'b01,2'b00,0);
  localparam logic [15:0] V_EXECRW   = ov(0,0,0,0,0,0,0,2'b11,2'b10,2'b00,2'b00,0);
  localparam logic [15:0] V_EXECIW   = ov(0,0,0,0,0,0,0,2'b11,2'b10,2'b01,2'b00,0);
  localparam logic [15:0] V_LUI      = ov(0,0,0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,0);
  localparam logic [15:0] V_AUIPC    = ov(0,0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0);
  localparam logic [15:0] V_ALUWB    = ov(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
  localparam logic [15:0] V_BRANCH   = ov(0,0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,0);
  localparam logic [15:0] V_JALR     = ov(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0);
  localparam logic [15:0] V_JAL      = ov(0,0,0,0,1,0,0,2'b00,2'b01,2'b10,2'b00,0);

  // Instruction classes
  localparam int C_ILL = 0, C_LOAD = 1, C_STORE = 2, C_R = 3, C_I = 4, C_RW = 5,
                 C_IW = 6, C_BR = 7, C_JAL = 8, C_JALR = 9, C_LUI = 10, C_AUIPC = 11;

  function automatic int op_class(input logic [6:0] op);
    case (op)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0111011: return C_RW;
      7'b0011011: return C_IW;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [6:0] pick_op();
    logic [6:0] tbl [11];
    int k;
    tbl = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    k = int'($urandom_range(0, 12));
    if (k >= 11) return 7'($urandom);
    return tbl[k];
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, then sample.
  task automatic cyc(input logic [6:0] op, input logic rdy, input logic [15:0] exp,
                     input string tag);
    @(negedge clk);
    i_op        = op;
    i_mem_ready = rdy;
    #1;
    chk(tag, outv, exp);
  endtask

  // Expand one instruction into its expected step list and walk it.
  // fw/mw: fetch / data-memory wait cycles, negative means random.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    int cls;
    int nf;
    int nm;
    cls = op_class(op);
    nf  = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
    nm  = (mw < 0) ? int'($urandom_range(0, 3)) : mw;

    for (int i = 0; i < nf; i++) cyc(op, 1'b0, V_FETCH_W, "fetch_wait");
    cyc(op, 1'b1, V_FETCH_R, "fetch_ready");
    cyc(op, rnd_bit(), V_DECODE | {15'd0, cls == C_ILL}, "decode");

    case (cls)
      C_LOAD: begin
        cyc(op, rnd_bit(), V_MEMADDR, "memaddr");
        for (int i = 0; i < nm; i++) cyc(op, 1'b0, V_MEMREAD, "memread_wait");
        cyc(op, 1'b1, V_MEMREAD, "memread_ready");
        cyc(op, rnd_bit(), V_MEMWB, "memwb");
      end
      C_STORE: begin
        cyc(op, rnd_bit(), V_MEMADDR, "memaddr");
        for (int i = 0; i < nm; i++) cyc(op, 1'b0, V_MEMWRITE, "memwrite_wait");
        cyc(op, 1'b1, V_MEMWRITE, "memwrite_ready");
      end
      C_R:     begin cyc(op, rnd_bit(), V_EXECR,  "execr");  cyc(op, rnd_bit(), V_ALUWB, "aluwb"); end
      C_I:     begin cyc(op, rnd_bit(), V_EXECI,  "execi");  cyc(op, rnd_bit(), V_ALUWB, "aluwb"); end
      C_RW:    begin cyc(op, rnd_bit(), V_EXECRW, "execrw"); cyc(op, rnd_bit(), V_ALUWB, "aluwb"); end
      C_IW:    begin cyc(op, rnd_bit(), V_EXECIW, "execiw"); cyc(op, rnd_bit(), V_ALUWB, "aluwb"); end
      C_LUI:   begin cyc(op, rnd_bit(), V_LUI,    "lui");    cyc(op, rnd_bit(), V_ALUWB, "aluwb"); end
      C_AUIPC: begin cyc(op, rnd_bit(), V_AUIPC,  "auipc");  cyc(op, rnd_bit(), V_ALUWB, "aluwb"); end
      C_BR:    cyc(op, rnd_bit(), V_BRANCH, "branch");
      C_JAL: begin
        cyc(op, rnd_bit(), V_JAL,   "jal");
        cyc(op, rnd_bit(), V_ALUWB, "aluwb");
      end
      C_JALR: begin
        cyc(op, rnd_bit(), V_JALR,  "jalr");
        cyc(op, rnd_bit(), V_JAL,   "jal");
        cyc(op, rnd_bit(), V_ALUWB, "aluwb");
      end
      default: ;  // illegal: straight back to fetch
    endcase
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    arstn       = 1'b0;
    i_op        = 7'd0;
    i_mem_ready = 1'b0;

    // Held in reset: outputs low regardless of ready
    cyc(7'd0, 1'b1, V_ZERO, "in_reset");
    cyc(7'd0, 1'b0, V_ZERO, "in_reset");

    // Release; first cycle after release is IDLE
    @(negedge clk);
    arstn = 1'b1;
    #1;
    chk("idle", outv, V_ZERO);

    // Directed scenarios
    run_instr(7'b0010011, 0, 0);   // ADDI
    run_instr(7'b0000011, 0, 3);   // load, 3 wait cycles in MEMREAD
    run_instr(7'b1100011, 0, 0);   // BEQ
    run_instr(7'b1100111, 0, 0);   // JALR
    run_instr(7'b1111111, 0, 0);   // illegal
    run_instr(7'b0100011, 2, 1);   // store with fetch and write waits

    // Reset in the middle of a MEMWRITE wait
    cyc(7'b0100011, 1'b1, V_FETCH_R,  "rst_fetch");
    cyc(7'b0100011, 1'b0, V_DECODE,   "rst_decode");
    cyc(7'b0100011, 1'b0, V_MEMADDR,  "rst_memaddr");
    cyc(7'b0100011, 1'b0, V_MEMWRITE, "rst_memwrite_wait");
    #2;
    arstn = 1'b0;
    #1;
    chk("rst_async_drop", outv, V_ZERO);
    cyc(7'b0100011, 1'b1, V_ZERO, "rst_held");
    @(negedge clk);
    arstn       = 1'b1;
    i_mem_ready = 1'b1;
    #1;
    chk("rst_idle", outv, V_ZERO);
    run_instr(7'b0110011, 1, 0);   // restarts at FETCH

    // Random instruction stream with random wait states
    for (int n = 0; n < 300; n++) begin
      run_instr(pick_op(), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multi-cycle control unit for the RV64I core. It sequences the shared ALU, register file and unified instruction/data memory over several cycles per instruction, and drives the ALU decoder through a 2-bit ALU-op code. It sits between the instruction register opcode field and all datapath enables and multiplexer selects. It waits on a ready/request handshake to the memory.

## Interface
- No parameters.
- clk  in  1  core clock, rising edge.
- arstn  in  1  asynchronous active-low reset.
- i_op  in  7  opcode field of the instruction register.
- i_mem_ready  in  1  memory has completed the current access this cycle.
- o_mem_req  out  1  memory access request; held until i_mem_ready.
- o_mem_write  out  1  request is a store.
- o_addr_src  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- o_instr_write  out  1  load the instruction register.
- o_pc_update  out  1  unconditional PC write.
- o_branch  out  1  conditional PC write; the datapath qualifies it with the compare result.
- o_reg_write  out  1  register file write enable.
- o_alu_op  out  2  00 add, 01 sub, 10 I/R decode, 11 W decode.
- o_alu_src_a  out  2  00 PC, 01 old PC, 10 rs1 register, 11 zero.
- o_alu_src_b  out  2  00 rs2 register, 01 immediate, 10 constant 4.
- o_result_src  out  2  00 ALU-out register, 01 read-data register, 10 ALU result.
- o_illegal_instr  out  1  one-cycle pulse on an unknown opcode.

## Operation
- States: IDLE, FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, EXECRW, EXECIW, ALUWB, BRANCH, JALR, JAL, LUI, AUIPC.
- Defaults in every state: all 1-bit outputs 0, all selects 00, unless listed below.
- IDLE: entered on reset. All outputs 0. Goes to FETCH next cycle.
- FETCH: mem_req=1, addr_src=0.
  - While i_mem_ready=0, all other outputs stay 0 and the state holds.
  - In the ready cycle: instr_write=1, pc_update=1, src_a=00, src_b=10, result_src=10, alu_op=00. Then go to DECODE.
- DECODE: src_a=01, src_b=01, alu_op=00 (latches the branch/JAL target into ALU-out). Next state by i_op:
  - 0000011 or 0100011 → MEMADDR
  - 0110011 → EXECR; 0010011 → EXECI; 0111011 → EXECRW; 0011011 → EXECIW
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR
  - 0110111 → LUI; 0010111 → AUIPC
  - anything else: o_illegal_instr=1 this cycle, then FETCH.
- MEMADDR: src_a=10, src_b=01, alu_op=00. Goes to MEMREAD if i_op[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, addr_src=1. Holds until ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, addr_src=1. Holds until ready, then FETCH.
- Execute states, all followed by ALUWB:
  - EXECR: src_a=10, src_b=00, alu_op=10.
  - EXECI: src_a=10, src_b=01, alu_op=10.
  - EXECRW / EXECIW: same selects as EXECR / EXECI, with alu_op=11.
  - LUI: src_a=11, src_b=01, alu_op=00.
  - AUIPC: src_a=01, src_b=01, alu_op=00.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00, branch=1. Goes to FETCH.
- JALR: src_a=10, src_b=01, alu_op=00. Goes to JAL.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_update=1. Goes to ALUWB, which writes old PC + 4.

## Timing
- Outputs are combinational from the state. In FETCH, instr_write and pc_update are additionally gated by i_mem_ready (Mealy).
- No combinational path from i_op to any output except o_illegal_instr in DECODE.
- Cycle counts with zero-wait memory (ready in the first request cycle), IDLE excluded:
  - R/I/W/LUI/AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
- Each wait cycle adds one cycle.
- o_mem_req stays high, and its address/selects stay stable, from the first request cycle through the ready cycle.
- i_mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Reset asserted at any point, including mid-access: state goes to IDLE immediately and all outputs drop to 0 asynchronously. The pending memory request is abandoned.

## Structure
- Shared package `core_pkg`: state enum, opcode constants, ALU-op encodings, and src_a/src_b/result_src encodings (also used by the datapath and the ALU decoder).
- Single module: state register, next-state logic, output decode. No sub-module.

## Test plan
- Reset release, then ADDI (i_op=0010011) with i_mem_ready=1: IDLE→FETCH→DECODE→EXECI→ALUWB→FETCH. alu_op=10 in EXECI; reg_write=1 only in ALUWB.
- Load with i_mem_ready held low 3 cycles in MEMREAD: mem_req=1 and addr_src=1 stable for 4 cycles, then MEMWB with result_src=01.
- BEQ (1100011): BRANCH asserts branch=1, alu_op=01, result_src=00 for exactly one cycle. pc_update stays 0.
- JALR (1100111): states DECODE→JALR→JAL→ALUWB. pc_update=1 only in JAL and in the FETCH ready cycle.
- i_op=1111111 in DECODE: o_illegal_instr high exactly one cycle, next state FETCH, reg_write/mem_write never asserted.
- arstn dropped during MEMWRITE wait: all outputs 0 in the same cycle; after release, the sequence restarts at IDLE→FETCH.
